mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single main-memory line port between the instruction cache (line fills) and the data cache (line fills and write-backs).
- Sits between both caches and the external memory model.
- Serializes requests with a fixed priority, or optionally round-robin.
- Registers address, data and control on the memory side, and returns data and acks to the winning cache as one-cycle pulses.

Parameters:
- ADDR_W, 26, line address width (word address bits above the 16-byte offset).
- LINE_W, 128, cache line width in bits.
- TIMEOUT, 255, maximum cycles to wait for mem_ready before aborting; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  I-cache fill request; level, held until i_ready
- i_addr  in  ADDR_W  I-cache fill line address
- i_rdata  out  LINE_W  fill data returned to the I-cache
- i_ready  out  1  one-cycle pulse; i_rdata valid this cycle
- d_req  in  1  D-cache fill request; level, held until d_ready
- d_addr  in  ADDR_W  D-cache fill line address
- d_rdata  out  LINE_W  fill data returned to the D-cache
- d_ready  out  1  one-cycle pulse; d_rdata valid this cycle
- d_wreq  in  1  D-cache write-back request; level, held until d_wack
- d_waddr  in  ADDR_W  write-back line address
- d_wdata  in  LINE_W  write-back line data
- d_wack  out  1  one-cycle pulse; write-back done
- mem_req  out  1  memory request; level
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_W  memory line address
- mem_wdata  out  LINE_W  memory write data
- mem_rdata  in  LINE_W  memory read data; valid with mem_ready on reads
- mem_ready  in  1  memory completion (read data valid or write acknowledged)
- busy  out  1  high in any state other than IDLE
- grant  out  2  current owner: 0 none, 1 I-read, 2 D-read, 3 D-write
- err  out  1  sticky watchdog timeout flag

Behaviour:
- Reset: every output is 0 (i_rdata, d_rdata, mem_addr, mem_wdata cleared), state IDLE, watchdog counter 0, round-robin pointer at D. Reset mid-transaction aborts immediately; no ack is issued.
- States: IDLE, ISSUE, WAIT, RESP, RELEASE.
- IDLE: sample the requests and select a winner.
  - Fixed priority: d_wreq > d_req > i_req.
  - Latch address, data and mem_we; set grant; go to ISSUE.
  - No request pending: stay in IDLE.
- ISSUE: assert mem_req (registered, so visible the cycle after selection); go to WAIT.
- WAIT: hold mem_req, mem_we, mem_addr and mem_wdata stable.
  - On mem_ready: drop mem_req next cycle, capture mem_rdata on reads, go to RESP.
- RESP: pulse exactly one of i_ready, d_ready or d_wack for one cycle, with captured data on i_rdata/d_rdata.
  - The other data output holds its previous value.
  - Go to RELEASE.
- RELEASE: one idle cycle so the served requester can drop its request. Requests are ignored; clear grant; go to IDLE.
- Minimum latency: 4 cycles from request seen in IDLE to ready pulse, when mem_ready is asserted in the first WAIT cycle.
- mem_ready is ignored outside WAIT.
- A request dropped before its ack does not cancel the in-flight memory access. The ack still pulses and the requester ignores it.
- Simultaneous d_wreq and d_req: the write-back is served first. This keeps dirty-line eviction ahead of the refill of the same set.
- Watchdog (TIMEOUT > 0):
  - The counter increments each WAIT cycle and clears on leaving WAIT.
  - When the counter reaches TIMEOUT: set err, drop mem_req, go to RELEASE with no ack.
  - err stays high until reset.
- Address and data registers change only on selection in IDLE.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin between the I and D classes, where the D class means d_wreq before d_req.
  - A 1-bit pointer names the class that loses the next contended pick.
  - The pointer toggles to the just-served class on entering RESP.
  - Reset value of the pointer: D loses, so I wins the first contended pick.
- Undefined: fixed priority as above; the pointer logic is absent.

Test Plan:
- i_req=1, i_addr=0x0000040, mem_ready one cycle after mem_req rises, mem_rdata=0x1111_..._1111 -> mem_we=0, mem_addr=0x0000040; i_ready pulses once, 4 cycles after the request, with i_rdata=0x1111_..._1111; grant=1, then 0.
- d_wreq and d_req asserted together (waddr 0x10, addr 0x20, wdata 0xAAAA_..._AAAA) -> first access mem_we=1, addr 0x10, d_wack; second access mem_we=0, addr 0x20, d_ready; never overlapped.
- i_req and d_req held together, fixed priority -> D served first. Under MEM_ARB_RR_EN, grants go I, D, I for three back-to-back requests with continuously held requests.
- mem_ready delayed 10 cycles -> mem_req and mem_addr stable throughout WAIT; ready asserted 13 cycles after the request.
- TIMEOUT=8, mem_ready never asserted -> err=1 at the 8th WAIT cycle, no ack, busy returns to 0 two cycles later; the next i_req is served normally with err still 1.
- reset asserted during WAIT -> next cycle all outputs 0 and state IDLE; a late mem_ready produces no ack.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single main-memory line port between the I-cache (line fills)
//   and the D-cache (line fills and write-backs). One access is in flight at a
//   time; the memory side is fully registered and the winning cache receives
//   its data and ack as a one-cycle pulse.
//
//   Selection is fixed priority d_wreq > d_req > i_req. Defining the macro
//   MEM_ARB_RR_EN switches to round-robin between the I class and the D class
//   (inside the D class the write-back still goes first).
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   i_req/i_addr               I-cache fill request (level) and line address
//   i_rdata/i_ready            fill data and its one-cycle valid pulse
//   d_req/d_addr               D-cache fill request (level) and line address
//   d_rdata/d_ready            fill data and its one-cycle valid pulse
//   d_wreq/d_waddr/d_wdata     D-cache write-back request, address, line
//   d_wack                     one-cycle write-back done pulse
//   mem_req/mem_we/mem_addr/mem_wdata   registered memory request
//   mem_rdata/mem_ready        memory read data and completion
//   busy, grant, err           status: not idle, current owner, sticky timeout
//
//   state   | meaning
//   IDLE    | pick a winner, latch address/data/direction
//   ISSUE   | mem_req first visible
//   WAIT    | hold the request until mem_ready or watchdog expiry
//   RESP    | drive the ack pulse for the served requester
//   RELEASE | one dead cycle so the served requester can drop its request

module mem_port_arbiter #(
  parameter int ADDR_W  = 26,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  input  logic              d_wreq,
  input  logic [ADDR_W-1:0] d_waddr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_wack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic [1:0]        grant,
  output logic              err
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_RELEASE} state_t;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_IRD  = 2'd1;
  localparam logic [1:0] G_DRD  = 2'd2;
  localparam logic [1:0] G_DWR  = 2'd3;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Fire on the TIMEOUT-th WAIT cycle: the counter holds the number of WAIT
  // cycles already completed.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d, sel_grant;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic                i_ready_q, i_ready_d, d_ready_q, d_ready_d, d_wack_q, d_wack_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    wdog_q, wdog_d;
  logic                wdog_fire;

`ifdef MEM_ARB_RR_EN
  // rr_q names the class that loses the next contended pick.
  localparam logic RR_I = 1'b0;
  localparam logic RR_D = 1'b1;
  logic rr_q, rr_d;
`endif

  assign wdog_fire = (TIMEOUT != 0) && (wdog_q == CNT_LAST);

  always_comb begin
    sel_grant = G_NONE;
    if (d_wreq)     sel_grant = G_DWR;
    else if (d_req) sel_grant = G_DRD;
    else if (i_req) sel_grant = G_IRD;
`ifdef MEM_ARB_RR_EN
    if (i_req && (d_wreq || d_req) && (rr_q == RR_D)) sel_grant = G_IRD;
`endif
  end

  // State register (all sequential state of the block)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= G_NONE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      d_wack_q    <= 1'b0;
      err_q       <= 1'b0;
      wdog_q      <= '0;
`ifdef MEM_ARB_RR_EN
      rr_q        <= RR_D;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      d_wack_q    <= d_wack_d;
      err_q       <= err_d;
      wdog_q      <= wdog_d;
`ifdef MEM_ARB_RR_EN
      rr_q        <= rr_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (sel_grant != G_NONE) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT: begin
        if (mem_ready)      state_d = S_RESP;
        else if (wdog_fire) state_d = S_RELEASE;
      end
      S_RESP:    state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    grant_d     = grant_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;
    wdog_d      = '0;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    d_wack_d    = 1'b0;
    // Registered, so the request is visible from the ISSUE cycle and drops
    // the cycle after mem_ready or watchdog expiry.
    mem_req_d   = (state_d == S_ISSUE) || (state_d == S_WAIT);
`ifdef MEM_ARB_RR_EN
    rr_d        = rr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sel_grant != G_NONE) begin
          grant_d  = sel_grant;
          mem_we_d = (sel_grant == G_DWR);
          case (sel_grant)
            G_IRD:   mem_addr_d = i_addr;
            G_DRD:   mem_addr_d = d_addr;
            default: mem_addr_d = d_waddr;
          endcase
          if (sel_grant == G_DWR) mem_wdata_d = d_wdata;
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          if (grant_q == G_IRD)      i_rdata_d = mem_rdata;
          else if (grant_q == G_DRD) d_rdata_d = mem_rdata;
`ifdef MEM_ARB_RR_EN
          rr_d = (grant_q == G_IRD) ? RR_I : RR_D;
`endif
        end else if (wdog_fire) begin
          err_d = 1'b1;
        end else if (TIMEOUT != 0) begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_RESP: begin
        i_ready_d = (grant_q == G_IRD);
        d_ready_d = (grant_q == G_DRD);
        d_wack_d  = (grant_q == G_DWR);
      end
      S_RELEASE: grant_d = G_NONE;
      default: ;
    endcase
  end

  assign i_rdata   = i_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_wack    = d_wack_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign grant     = grant_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: main instance with the default
// watchdog, second instance with TIMEOUT=8 for the abort path.
module tb_mem_port_arbiter;

  localparam int AW = 26;
  localparam int LW = 128;
  localparam logic [LW-1:0] PAT_1 = {32{4'h1}};
  localparam logic [LW-1:0] PAT_2 = {32{4'h2}};
  localparam logic [LW-1:0] PAT_3 = {32{4'h3}};
  localparam logic [LW-1:0] PAT_4 = {32{4'h4}};
  localparam logic [LW-1:0] PAT_5 = {32{4'h5}};
  localparam logic [LW-1:0] PAT_A = {32{4'hA}};

`ifdef MEM_ARB_RR_EN
  localparam logic [1:0] EXP_G1 = 2'd1;
  localparam logic [1:0] EXP_G2 = 2'd2;
  localparam logic [1:0] EXP_G3 = 2'd1;
`else
  localparam logic [1:0] EXP_G1 = 2'd2;
  localparam logic [1:0] EXP_G2 = 2'd2;
  localparam logic [1:0] EXP_G3 = 2'd2;
`endif

  logic clk = 1'b0;
  logic reset;
  logic i_req, d_req, d_wreq, mem_ready;
  logic [AW-1:0] i_addr, d_addr, d_waddr, mem_addr;
  logic [LW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
  logic i_ready, d_ready, d_wack, mem_req, mem_we, busy, err;
  logic [1:0] grant;

  logic w_i_req, w_mem_ready;
  logic [AW-1:0] w_i_addr, w_mem_addr;
  logic [LW-1:0] w_i_rdata, w_d_rdata, w_mem_wdata, w_mem_rdata;
  logic w_i_ready, w_d_ready, w_d_wack, w_mem_req, w_mem_we, w_busy, w_err;
  logic [1:0] w_grant;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_addr(d_addr), .d_rdata(d_rdata), .d_ready(d_ready),
    .d_wreq(d_wreq), .d_waddr(d_waddr), .d_wdata(d_wdata), .d_wack(d_wack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .grant(grant), .err(err)
  );

  mem_port_arbiter #(.TIMEOUT(8)) u_wd (
    .clk(clk), .reset(reset),
    .i_req(w_i_req), .i_addr(w_i_addr), .i_rdata(w_i_rdata), .i_ready(w_i_ready),
    .d_req(1'b0), .d_addr('0), .d_rdata(w_d_rdata), .d_ready(w_d_ready),
    .d_wreq(1'b0), .d_waddr('0), .d_wdata('0), .d_wack(w_d_wack),
    .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
    .mem_rdata(w_mem_rdata), .mem_ready(w_mem_ready),
    .busy(w_busy), .grant(w_grant), .err(w_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ack_of(input logic [1:0] g);
    case (g)
      2'd1:    return 3'b100;
      2'd2:    return 3'b010;
      2'd3:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Waits (bounded) for mem_req, records the request, holds mem_ready low for
  // 'delay' cycles after the first mem_req cycle, then pulses it once.
  task automatic serve(input int delay, input logic [LW-1:0] rdata,
                       output logic [1:0] g, output logic we,
                       output logic [AW-1:0] addr, output logic [LW-1:0] wdata,
                       output logic stable);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("mem_req_seen", 128'(mem_req), 128'd1);
    g = grant; we = mem_we; addr = mem_addr; wdata = mem_wdata; stable = 1'b1;
    repeat (delay) begin
      step();
      if (mem_req !== 1'b1 || mem_addr !== addr || mem_we !== we || mem_wdata !== wdata)
        stable = 1'b0;
    end
    mem_ready = 1'b1;
    mem_rdata = rdata;
    step();
    mem_ready = 1'b0;
  endtask

  // Waits (bounded) for any ack pulse; returns {i_ready,d_ready,d_wack}.
  task automatic wait_ack(output logic [2:0] vec);
    vec = 3'b000;
    for (int n = 0; n < 30; n++) begin
      step();
      vec = {i_ready, d_ready, d_wack};
      if (vec != 3'b000) break;
    end
  endtask

  logic [1:0] g;
  logic we, stable;
  logic [AW-1:0] a;
  logic [LW-1:0] wd;
  logic [2:0] av;
  int t0;
  logic seen;

  initial begin
    reset = 1'b1;
    i_req = 0; d_req = 0; d_wreq = 0; mem_ready = 0;
    i_addr = '0; d_addr = '0; d_waddr = '0; d_wdata = '0; mem_rdata = '0;
    w_i_req = 0; w_i_addr = '0; w_mem_ready = 0; w_mem_rdata = '0;
    step();
    step();
    chk("rst_acks", 128'({i_ready, d_ready, d_wack}), 128'd0);
    chk("rst_mem", 128'({mem_req, mem_we, busy, err, grant}), 128'd0);
    chk("rst_addr", 128'(mem_addr), 128'd0);
    chk("rst_data", i_rdata | d_rdata | mem_wdata, 128'd0);
    reset = 1'b0;
    step();

    // I-cache fill, minimum latency
    t0 = cyc;
    i_req = 1'b1; i_addr = 26'h40;
    step();
    chk("t1_mem_req", 128'(mem_req), 128'd1);
    chk("t1_mem_we", 128'(mem_we), 128'd0);
    chk("t1_mem_addr", 128'(mem_addr), 128'h40);
    chk("t1_grant", 128'(grant), 128'd1);
    step();
    mem_ready = 1'b1; mem_rdata = PAT_1;
    chk("t1_req_hold", 128'(mem_req), 128'd1);
    step();
    mem_ready = 1'b0;
    chk("t1_req_drop", 128'(mem_req), 128'd0);
    chk("t1_no_early_ack", 128'(i_ready), 128'd0);
    step();
    chk("t1_ack", 128'({i_ready, d_ready, d_wack}), 128'b100);
    chk("t1_rdata", i_rdata, PAT_1);
    chk("t1_latency", 128'(cyc - t0), 128'd4);
    i_req = 1'b0;
    step();
    chk("t1_pulse_end", 128'(i_ready), 128'd0);
    chk("t1_grant_clr", 128'(grant), 128'd0);
    chk("t1_idle", 128'(busy), 128'd0);

    // Write-back and fill together: write-back first, no overlap
    d_wreq = 1'b1; d_req = 1'b1; d_waddr = 26'h10; d_addr = 26'h20; d_wdata = PAT_A;
    serve(1, PAT_5, g, we, a, wd, stable);
    chk("t2_wb_we", 128'(we), 128'd1);
    chk("t2_wb_addr", 128'(a), 128'h10);
    chk("t2_wb_data", wd, PAT_A);
    wait_ack(av);
    chk("t2_wb_ack", 128'(av), 128'b001);
    chk("t2_no_overlap", 128'(mem_req), 128'd0);
    d_wreq = 1'b0;
    serve(1, PAT_2, g, we, a, wd, stable);
    chk("t2_fill_we", 128'(we), 128'd0);
    chk("t2_fill_addr", 128'(a), 128'h20);
    wait_ack(av);
    chk("t2_fill_ack", 128'(av), 128'b010);
    chk("t2_fill_data", d_rdata, PAT_2);
    d_req = 1'b0;

    // I and D fills held together across three accesses
    i_req = 1'b1; i_addr = 26'h100; d_req = 1'b1; d_addr = 26'h200;
    serve(1, PAT_3, g, we, a, wd, stable);
    chk("t3_grant1", 128'(g), 128'(EXP_G1));
    wait_ack(av);
    chk("t3_ack1", 128'(av), 128'(ack_of(EXP_G1)));
    serve(1, PAT_3, g, we, a, wd, stable);
    chk("t3_grant2", 128'(g), 128'(EXP_G2));
    wait_ack(av);
    chk("t3_ack2", 128'(av), 128'(ack_of(EXP_G2)));
    serve(1, PAT_3, g, we, a, wd, stable);
    chk("t3_grant3", 128'(g), 128'(EXP_G3));
    wait_ack(av);
    chk("t3_ack3", 128'(av), 128'(ack_of(EXP_G3)));
    i_req = 1'b0; d_req = 1'b0;
    step();

    // Slow memory: ready 10 cycles after mem_req rises
    t0 = cyc;
    i_req = 1'b1; i_addr = 26'h123;
    serve(10, PAT_4, g, we, a, wd, stable);
    chk("t4_addr", 128'(a), 128'h123);
    chk("t4_stable", 128'(stable), 128'd1);
    wait_ack(av);
    chk("t4_ack", 128'(av), 128'b100);
    chk("t4_latency", 128'(cyc - t0), 128'd13);
    chk("t4_rdata", i_rdata, PAT_4);
    i_req = 1'b0;
    step();

    // Reset during WAIT, then a late mem_ready
    i_req = 1'b1; i_addr = 26'h77;
    step();
    step();
    chk("t5_in_wait", 128'(mem_req), 128'd1);
    reset = 1'b1;
    step();
    reset = 1'b0; i_req = 1'b0;
    chk("t5_rst_out", 128'({mem_req, mem_we, busy, err, grant, i_ready, d_ready, d_wack}), 128'd0);
    chk("t5_rst_addr", 128'(mem_addr), 128'd0);
    chk("t5_rst_data", i_rdata | d_rdata | mem_wdata, 128'd0);
    mem_ready = 1'b1; mem_rdata = PAT_5;
    step();
    mem_ready = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      step();
      if (i_ready || d_ready || d_wack || mem_req) seen = 1'b1;
    end
    chk("t5_no_late_ack", 128'(seen), 128'd0);

    // Watchdog (TIMEOUT=8), mem_ready never asserted
    w_i_req = 1'b1; w_i_addr = 26'h55;
    seen = 1'b0;
    repeat (9) begin
      step();
      if (w_i_ready || w_d_ready || w_d_wack) seen = 1'b1;
    end
    chk("t6_err_before", 128'(w_err), 128'd0);
    chk("t6_req_held", 128'(w_mem_req), 128'd1);
    step();
    chk("t6_err_set", 128'(w_err), 128'd1);
    chk("t6_req_dropped", 128'(w_mem_req), 128'd0);
    chk("t6_busy_release", 128'(w_busy), 128'd1);
    step();
    chk("t6_busy_clear", 128'(w_busy), 128'd0);
    if (w_i_ready || w_d_ready || w_d_wack) seen = 1'b1;
    chk("t6_no_ack", 128'(seen), 128'd0);
    step();
    chk("t6_reissue", 128'(w_mem_req), 128'd1);
    chk("t6_reissue_addr", 128'(w_mem_addr), 128'h55);
    step();
    w_mem_ready = 1'b1; w_mem_rdata = PAT_5;
    step();
    w_mem_ready = 1'b0;
    step();
    chk("t6_ack", 128'({w_i_ready, w_d_ready, w_d_wack}), 128'b100);
    chk("t6_rdata", w_i_rdata, PAT_5);
    chk("t6_err_sticky", 128'(w_err), 128'd1);
    w_i_req = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
